matrix_scan_ctrl: RTL and testbench

Column-scan sequencer sitting directly upstream of column_select. For each column it drives select_first/select_next, starts the row-data transmitter for that column, waits for both to finish, then un-blanks the matrix for a programmable dwell before blanking and advancing. It owns frame timing, column index, and the global blank (output-disable) signal for the row drivers.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/scan_dwell_timer.sv | 27 ++
 rtl/matrix_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the LED matrix scan path.
// The row transmitter and column_select instantiations take their sizes from here.
package matrix_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEL_HOLD  = 3'd2,
      WAIT_DONE = 3'd3,
      ON        = 3'd4,
      BLANK     = 3'd5
   } scan_state_t;

   localparam int DEF_COLUMNS      = 16;
   localparam int DEF_ON_CYCLES    = 1024;
   localparam int DEF_BLANK_CYCLES = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Down-counter shared by the ON and BLANK dwell periods.
// done is high while the count sits at zero; the counter never wraps below zero.
module scan_dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column-scan sequencer: selects each column, starts the row load, then shows it
// for ON_CYCLES and blanks for BLANK_CYCLES before moving on. Outputs are registered.
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int COLUMNS      = DEF_COLUMNS,
   parameter int ON_CYCLES    = DEF_ON_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int COL_W        = $clog2(COLUMNS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             col_ready,
   output logic             select_first,
   output logic             select_next,
   output logic             row_start,
   input  logic             row_done,
   output logic [COL_W-1:0] col_idx,
   output logic             blank,
   output logic             frame_start
);

   localparam int TMR_W = $clog2(max_int(ON_CYCLES, BLANK_CYCLES) + 1);
   localparam logic [TMR_W-1:0] ON_LOAD    = TMR_W'(ON_CYCLES - 1);
   localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLUMNS - 1);

   scan_state_t      state_reg;
   scan_state_t      state_next;
   logic [COL_W-1:0] col_idx_reg;
   logic [COL_W-1:0] col_idx_next;
   logic             row_ok_reg;
   logic             select_first_reg;
   logic             select_next_reg;
   logic             row_start_reg;
   logic             blank_reg;
   logic             frame_start_reg;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_done;
   logic             selecting;

   scan_dwell_timer #(
      .W(TMR_W)
   ) u_dwell_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .done       (tmr_done)
   );

   always_comb begin
      state_next   = state_reg;
      col_idx_next = col_idx_reg;
      tmr_load     = 1'b0;
      tmr_value    = '0;
      case (state_reg)
         IDLE: begin
            if (enable && col_ready) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = SEL_HOLD;
         end
         SEL_HOLD: begin
            // column_select acknowledges by dropping col_ready while it shifts
            if (!col_ready) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (col_ready && (row_ok_reg || row_done)) begin
               state_next = ON;
               tmr_load   = 1'b1;
               tmr_value  = ON_LOAD;
            end
         end
         ON: begin
            if (tmr_done) begin
               state_next = BLANK;
               tmr_load   = 1'b1;
               tmr_value  = BLANK_LOAD;
            end
         end
         BLANK: begin
            if (tmr_done) begin
               if (enable) begin
                  state_next   = LOAD;
                  col_idx_next = (col_idx_reg == LAST_COL) ? '0 : col_idx_reg + COL_W'(1);
               end else begin
                  state_next   = IDLE;
                  col_idx_next = '0;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            col_idx_next = '0;
         end
      endcase
   end

   assign selecting = (state_next == LOAD) || (state_next == SEL_HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Outputs are decoded from the next state so they line up with state_reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_idx_reg      <= '0;
         select_first_reg <= 1'b0;
         select_next_reg  <= 1'b0;
         row_start_reg    <= 1'b0;
         frame_start_reg  <= 1'b0;
         blank_reg        <= 1'b1;
      end else begin
         col_idx_reg      <= col_idx_next;
         select_first_reg <= selecting && (col_idx_next == '0);
         select_next_reg  <= selecting && (col_idx_next != '0);
         row_start_reg    <= (state_next == LOAD);
         frame_start_reg  <= (state_next == LOAD) && (col_idx_next == '0);
         blank_reg        <= (state_next != ON);
      end
   end

   // Sticky completion flag so an early row_done during the select handshake survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_ok_reg <= 1'b0;
      end else if (state_reg == LOAD) begin
         row_ok_reg <= 1'b0;
      end else if (row_done && ((state_reg == SEL_HOLD) || (state_reg == WAIT_DONE))) begin
         row_ok_reg <= 1'b1;
      end
   end

   assign select_first = select_first_reg;
   assign select_next  = select_next_reg;
   assign row_start    = row_start_reg;
   assign col_idx      = col_idx_reg;
   assign blank        = blank_reg;
   assign frame_start  = frame_start_reg;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with small column_select and row transmitter models.
// Models act on the falling edge; the monitor records loads, ON lengths and select lengths.
module tb_matrix_scan_ctrl;

   localparam int COLUMNS = 4;
   localparam int ON_C    = 8;
   localparam int BLANK_C = 2;
   localparam int COL_W   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             col_ready = 1'b0;
   logic             row_done = 1'b0;
   logic             select_first;
   logic             select_next;
   logic             row_start;
   logic [COL_W-1:0] col_idx;
   logic             blank;
   logic             frame_start;

   matrix_scan_ctrl #(
      .COLUMNS      (COLUMNS),
      .ON_CYCLES    (ON_C),
      .BLANK_CYCLES (BLANK_C),
      .COL_W        (COL_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .col_ready    (col_ready),
      .select_first (select_first),
      .select_next  (select_next),
      .row_start    (row_start),
      .row_done     (row_done),
      .col_idx      (col_idx),
      .blank        (blank),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_value(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model controls, changed by the stimulus only just after a falling edge
   int cs_hold = 0;
   int cs_low = 1;
   int rd_delay = 0;
   bit cs_block = 1'b0;
   int cs_phase = 0;
   int cs_cnt = 0;
   int rd_cnt = 0;
   bit rd_active = 1'b0;
   int cr_rise_cyc = 0;

   always @(negedge clk) begin
      if (rst) begin
         cs_phase  = 0;
         col_ready = !cs_block;
         row_done  = 1'b0;
         rd_active = 1'b0;
      end else begin
         case (cs_phase)
            0: begin
               if (cs_block) begin
                  col_ready = 1'b0;
               end else if (!col_ready) begin
                  col_ready   = 1'b1;
                  cr_rise_cyc = cyc;
               end else if (select_first || select_next) begin
                  cs_phase = 1;
                  cs_cnt   = cs_hold;
               end
            end
            1: begin
               if (cs_cnt == 0) begin
                  col_ready = 1'b0;
                  cs_phase  = 2;
                  cs_cnt    = cs_low;
               end else begin
                  cs_cnt--;
               end
            end
            default: begin
               cs_cnt--;
               if (cs_cnt == 0) begin
                  col_ready   = 1'b1;
                  cs_phase    = 0;
                  cr_rise_cyc = cyc;
               end
            end
         endcase
         row_done = 1'b0;
         if (rd_active) begin
            if (rd_cnt == 0) begin
               row_done  = 1'b1;
               rd_active = 1'b0;
            end else begin
               rd_cnt--;
            end
         end else if (row_start) begin
            rd_active = 1'b1;
            rd_cnt    = rd_delay;
         end
      end
   end

   int load_q[$];
   int col_q[$];
   int sfirst_q[$];
   int snext_q[$];
   int fs_q[$];
   int on_q[$];
   int onlat_q[$];
   int sel_q[$];
   int fs_total = 0;
   int both_err = 0;
   int on_run = 0;
   int sel_run = 0;
   bit prev_blank = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         on_run     = 0;
         sel_run    = 0;
         prev_blank = 1'b1;
      end else begin
         if (row_start) begin
            load_q.push_back(cyc);
            col_q.push_back(int'(col_idx));
            sfirst_q.push_back(int'(select_first));
            snext_q.push_back(int'(select_next));
            fs_q.push_back(int'(frame_start));
         end
         if (frame_start) fs_total++;
         if (select_first && select_next) both_err++;
         if (select_first || select_next) begin
            sel_run++;
         end else if (sel_run != 0) begin
            sel_q.push_back(sel_run);
            sel_run = 0;
         end
         if (!blank) begin
            if (prev_blank && load_q.size() > 0) onlat_q.push_back(cyc - load_q[$]);
            on_run++;
         end else if (!prev_blank) begin
            on_q.push_back(on_run);
            on_run = 0;
         end
         prev_blank = blank;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_all();
      load_q.delete(); col_q.delete(); sfirst_q.delete(); snext_q.delete();
      fs_q.delete(); on_q.delete(); onlat_q.delete(); sel_q.delete();
      fs_total = 0;
   endtask

   task automatic restart();
      rst = 1'b1;
      tick();
      tick();
      clear_all();
      rst = 1'b0;
   endtask

   task automatic wait_loads(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && load_q.size() < n; i++) tick();
      check_value(tag, load_q.size(), n);
   endtask

   task automatic wait_on(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && on_q.size() < n; i++) tick();
      check_value(tag, on_q.size(), n);
   endtask

   int exp_col[5]   = '{0, 1, 2, 3, 0};
   int exp_first[5] = '{1, 0, 0, 0, 1};
   int exp_next[5]  = '{0, 1, 1, 1, 0};

   initial begin
      tick();
      tick();
      check_value("rst_blank", int'(blank), 1);
      check_value("rst_col", int'(col_idx), 0);
      check_value("rst_sel_first", int'(select_first), 0);
      check_value("rst_sel_next", int'(select_next), 0);
      check_value("rst_row_start", int'(row_start), 0);
      check_value("rst_frame_start", int'(frame_start), 0);

      // responsive neighbours: full frame plus wrap to column 0
      clear_all();
      rst = 1'b0;
      enable = 1'b1;
      wait_loads(5, 200, "a_loads");
      for (int i = 0; i < 5; i++) begin
         check_value($sformatf("a_col%0d", i), col_q[i], exp_col[i]);
         check_value($sformatf("a_first%0d", i), sfirst_q[i], exp_first[i]);
         check_value($sformatf("a_next%0d", i), snext_q[i], exp_next[i]);
         check_value($sformatf("a_fs%0d", i), fs_q[i], exp_first[i]);
      end
      for (int i = 0; i < 4; i++) begin
         check_value($sformatf("a_on_len%0d", i), on_q[i], ON_C);
         check_value($sformatf("a_period%0d", i), load_q[i+1] - load_q[i], ON_C + BLANK_C + 3);
      end
      check_value("a_latency", onlat_q[0], 3);
      check_value("a_sel_len", sel_q[0], 2);
      check_value("a_fs_total", fs_total, 2);

      // col_ready low after power-up stalls in IDLE
      cs_block = 1'b1;
      restart();
      repeat (50) tick();
      check_value("b_no_load", load_q.size(), 0);
      check_value("b_blank", int'(blank), 1);
      cs_block = 1'b0;
      wait_loads(1, 20, "b_load");
      check_value("b_load_delay", load_q[0] - cr_rise_cyc, 1);

      // row_done 20 cycles after col_ready returns
      rd_delay = 21;
      restart();
      wait_on(1, 100, "c1_on");
      check_value("c1_latency", onlat_q[0], 23);
      check_value("c1_on_len", on_q[0], ON_C);

      // row_done early, inside SEL_HOLD, must be remembered
      rd_delay = 0;
      cs_hold = 2;
      restart();
      wait_on(1, 100, "c2_on");
      check_value("c2_latency", onlat_q[0], 5);
      check_value("c2_sel_len", sel_q[0], 4);

      // enable dropped during ON of column 2, select held 3 cycles
      cs_hold = 1;
      restart();
      wait_loads(3, 200, "e_loads");
      repeat (7) tick();
      check_value("e_in_on", int'(blank), 0);
      check_value("e_col2", int'(col_idx), 2);
      enable = 1'b0;
      repeat (20) tick();
      check_value("e_stopped", load_q.size(), 3);
      check_value("e_col_idle", int'(col_idx), 0);
      check_value("e_blank_idle", int'(blank), 1);
      check_value("e_on_count", on_q.size(), 3);
      check_value("e_last_on", on_q[2], ON_C);
      check_value("e_sel_len", sel_q[0], 3);
      enable = 1'b1;
      wait_loads(4, 50, "e_reload");
      check_value("e_restart_col", col_q[3], 0);
      check_value("e_restart_first", sfirst_q[3], 1);
      check_value("e_restart_fs", fs_q[3], 1);

      // asynchronous reset in the middle of column 1 ON
      cs_hold = 0;
      restart();
      wait_loads(2, 100, "f_loads");
      repeat (5) tick();
      check_value("f_in_on", int'(blank), 0);
      check_value("f_col1", int'(col_idx), 1);
      rst = 1'b1;
      #1;
      check_value("f_async_blank", int'(blank), 1);
      check_value("f_async_col", int'(col_idx), 0);
      check_value("f_async_sel", int'(select_first | select_next), 0);
      clear_all();
      tick();
      tick();
      rst = 1'b0;
      wait_loads(2, 100, "f_reloads");
      check_value("f_first_col", col_q[0], 0);
      check_value("f_first_sel", sfirst_q[0], 1);
      check_value("f_first_fs", fs_q[0], 1);
      check_value("f_second_col", col_q[1], 1);

      check_value("sel_exclusive", both_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
